// File: rtl/ccff_loader.sv
// Configuration-chain loader: streams DATA_W-bit bitstream words MSB first
// into a CHAIN_LEN-bit configuration chain, one bit per ccff_shift cycle.
module ccff_loader #(
    parameter int DATA_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ccff_head,
    output logic              ccff_shift,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  bit_cnt
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | waiting for a bitstream word on din
    // SHIFT | driving one bit per cycle into the chain
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int               WC_W       = $clog2(DATA_W + 1);
    localparam logic [WC_W-1:0]  WORD_LAST  = WC_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              err_q, err_d;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        err_d      = err_q | (start & (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (din_valid) begin
                    sreg_d     = din;
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // The bit on ccff_head this cycle enters the chain even when
                // aborting, so it is always counted.
                sreg_d     = sreg_q << 1;
                bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                word_cnt_d = word_cnt_q + WC_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_cnt_q == CHAIN_LAST) begin
                    state_d = DONE;
                end else if (word_cnt_q == WORD_LAST) begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ccff_shift = (state_q == SHIFT);
    assign ccff_head  = ccff_shift & sreg_q[DATA_W-1];
    assign din_ready  = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: two instances (16-bit and 12-bit chains) share one
// stimulus driver; a scoreboard monitor checks head bits and done events.
module tb_ccff_loader;

    localparam int DW = 8;

    logic       CK = 1'b0;
    logic       RSTN, start, abort, din_valid;
    logic [7:0] din;
    logic       sel;
    int         cyc = 0;

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    logic st0, st1, ab0, ab1, dv0, dv1;
    assign st0 = start & ~sel;
    assign st1 = start & sel;
    assign ab0 = abort & ~sel;
    assign ab1 = abort & sel;
    assign dv0 = din_valid & ~sel;
    assign dv1 = din_valid & sel;

    logic        rdy0, head0, shift0, busy0, done0, err0;
    logic        rdy1, head1, shift1, busy1, done1, err1;
    logic [15:0] bc0, bc1;

    ccff_loader #(.DATA_W(8), .CHAIN_LEN(16), .CNT_W(16)) u_dut16 (
        .CK(CK), .RSTN(RSTN), .start(st0), .abort(ab0), .din(din), .din_valid(dv0),
        .din_ready(rdy0), .ccff_head(head0), .ccff_shift(shift0), .busy(busy0),
        .done(done0), .err(err0), .bit_cnt(bc0));

    ccff_loader #(.DATA_W(8), .CHAIN_LEN(12), .CNT_W(16)) u_dut12 (
        .CK(CK), .RSTN(RSTN), .start(st1), .abort(ab1), .din(din), .din_valid(dv1),
        .din_ready(rdy1), .ccff_head(head1), .ccff_shift(shift1), .busy(busy1),
        .done(done1), .err(err1), .bit_cnt(bc1));

    logic        w_ready, w_head, w_shift, w_busy, w_done, w_err;
    logic [15:0] w_bit_cnt;
    assign w_ready   = sel ? rdy1   : rdy0;
    assign w_head    = sel ? head1  : head0;
    assign w_shift   = sel ? shift1 : shift0;
    assign w_busy    = sel ? busy1  : busy0;
    assign w_done    = sel ? done1  : done0;
    assign w_err     = sel ? err1   : err0;
    assign w_bit_cnt = sel ? bc1    : bc0;

    bit exp_bits[$];
    int exp_done[$];
    bit exp_err[2];
    int total = 0;
    int bad   = 0;
    int last_done_cyc = 0;

    function automatic int chain_len();
        return sel ? 12 : 16;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge CK);
    endtask

    // Scoreboard monitor: every shift cycle consumes one expected bit,
    // every done pulse consumes one expected completion.
    always @(negedge CK) begin
        bit eb;
        int ec;
        if (w_shift) begin
            if (exp_bits.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_shift: shift=1 with no bits expected (t=%0t)", $time);
            end else begin
                eb = exp_bits.pop_front();
                check("head_bit", w_head, eb);
            end
        end else begin
            check("head_when_idle", w_head, 0);
        end
        if (w_done) begin
            last_done_cyc = cyc;
            if (exp_done.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: done pulse with none expected (t=%0t)", $time);
            end else begin
                ec = exp_done.pop_front();
                check("done_bit_cnt", w_bit_cnt, ec);
                check("done_bits_left", exp_bits.size(), 0);
                check("done_busy", w_busy, 1);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!w_ready && n < 50) begin
            tick();
            n++;
        end
        if (!w_ready) begin
            total++; bad++;
            $display("FAIL wait_ready: din_ready never rose (t=%0t)", $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_shift"}, w_shift, 0);
        check({tag, "_head"}, w_head, 0);
        check({tag, "_ready"}, w_ready, 0);
        check({tag, "_busy"}, w_busy, 0);
        check({tag, "_done"}, w_done, 0);
        check({tag, "_err"}, w_err, 0);
        check({tag, "_bit_cnt"}, w_bit_cnt, 0);
    endtask

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                            input int st_lo, input int st_hi,
                            input bit poke, input bit abort_at_start);
        logic [7:0]  wd[2];
        logic [15:0] held;
        int len, sent, stalls, t0, n, s;
        wd[0] = w0;
        wd[1] = w1;
        len = chain_len();
        sent = 0;
        stalls = 0;
        for (int i = 0; i < 2; i++)
            for (int b = DW - 1; b >= 0; b--)
                if (sent < len) begin
                    exp_bits.push_back(wd[i][b]);
                    sent++;
                end
        exp_done.push_back(len);

        start = 1'b1;
        abort = abort_at_start;
        tick();
        start = 1'b0;
        abort = 1'b0;
        t0 = cyc;
        check("load_busy", w_busy, 1);

        for (int i = 0; i < 2; i++) begin
            wait_ready();
            s = int'($urandom_range(st_hi, st_lo));
            stalls += s;
            held = w_bit_cnt;
            for (int j = 0; j < s; j++) begin
                check("stall_ready", w_ready, 1);
                check("stall_shift", w_shift, 0);
                check("stall_bit_cnt", w_bit_cnt, held);
                tick();
            end
            din = wd[i];
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            din = 8'($urandom);
            if (poke && i == 0) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                exp_err[sel] = 1'b1;
            end
        end

        n = 0;
        while (exp_done.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        if (exp_done.size() != 0) begin
            total++; bad++;
            $display("FAIL load_done: no done pulse within bound (t=%0t)", $time);
            exp_done.delete();
            exp_bits.delete();
        end else begin
            check("latency", last_done_cyc - t0, 2 + len + stalls);
        end
        tick();
        check("after_busy", w_busy, 0);
        check("after_bit_cnt", w_bit_cnt, len);
        check("err_flag", w_err, exp_err[sel]);
    endtask

    task automatic run_abort(input logic [7:0] w, input int k);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = DW - 1; b > DW - 1 - k; b--) exp_bits.push_back(w[b]);
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int j = 1; j < k; j++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_shift", w_shift, 0);
        check("abort_busy", w_busy, 0);
        check("abort_done", w_done, 0);
        check("abort_bit_cnt", w_bit_cnt, k);
        tick();
        check("abort_bits_left", exp_bits.size(), 0);
        check("abort_still_idle", w_busy, 0);
    endtask

    task automatic abort_in_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("aload_ready", w_ready, 1);
        abort = 1'b1;
        din_valid = 1'b1;
        din = 8'hFF;
        tick();
        abort = 1'b0;
        din_valid = 1'b0;
        check("aload_busy", w_busy, 0);
        check("aload_bit_cnt", w_bit_cnt, 0);
        tick();
        tick();
        check("aload_no_shift", w_shift, 0);
    endtask

    task automatic reset_mid_shift(input logic [7:0] w);
        for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(w[b]);
        start = 1'b1;
        tick();
        start = 1'b0;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        check("pre_reset_shift", w_shift, 1);
        #2 RSTN = 1'b0;
        #1 check_reset_outputs("async_rst");
        exp_bits.delete();
        exp_done.delete();
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        din = '0;
        din_valid = 1'b0;
        sel = 1'b0;
        exp_err[0] = 1'b0;
        exp_err[1] = 1'b0;
        tick();
        #1 check_reset_outputs("rst16");
        sel = 1'b1;
        #1 check_reset_outputs("rst12");
        sel = 1'b0;
        tick();
        RSTN = 1'b1;
        tick();

        sel = 1'b0;
        run_load(8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0);
        repeat (4) run_load(8'($urandom), 8'($urandom), 0, 3, 1'b0, 1'b0);
        run_load(8'($urandom), 8'($urandom), 5, 5, 1'b0, 1'b0);
        run_load(8'($urandom), 8'($urandom), 0, 2, 1'b1, 1'b0);
        run_load(8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b1);
        reset_mid_shift(8'hC3);
        RSTN = 1'b1;
        run_load(8'($urandom), 8'($urandom), 0, 1, 1'b0, 1'b0);

        sel = 1'b1;
        tick();
        run_load(8'hFF, 8'h0F, 0, 0, 1'b0, 1'b0);
        repeat (4) run_load(8'($urandom), 8'($urandom), 0, 3, 1'b0, 1'b0);
        run_abort(8'hA5, 3);
        run_load(8'($urandom), 8'($urandom), 0, 0, 1'b0, 1'b0);
        repeat (3) run_abort(8'($urandom), int'($urandom_range(7, 1)));
        abort_in_load();
        run_load(8'($urandom), 8'($urandom), 0, 2, 1'b1, 1'b0);
        run_load(8'($urandom), 8'($urandom), 0, 4, 1'b0, 1'b1);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the bitstream word width.
REQ-002 The block SHALL have parameter CHAIN_LEN, default 1024, giving the total configuration-chain length in bits.
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the bit-counter width; CNT_W SHALL be large enough to hold CHAIN_LEN.
REQ-004 The block SHALL have port CK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RSTN, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to begin a chain load.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of the load in progress.
REQ-008 The block SHALL have port din, input, DATA_W bits: bitstream word, shifted out MSB first.
REQ-009 The block SHALL have port din_valid, input, 1 bit: din holds a valid word.
REQ-010 The block SHALL have port din_ready, output, 1 bit: the loader accepts din this cycle.
REQ-011 The block SHALL have port ccff_head, output, 1 bit: serial data to the configuration-chain head.
REQ-012 The block SHALL have port ccff_shift, output, 1 bit: chain shift enable; the chain advances on the CK edge that ends a cycle in which ccff_shift=1.
REQ-013 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse on load completion.
REQ-015 The block SHALL have port err, output, 1 bit: sticky protocol error flag.
REQ-016 The block SHALL have port bit_cnt, output, CNT_W bits: number of bits shifted in the current or last load.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, SHIFT and DONE.
REQ-018 IDLE: busy=0, din_ready=0, ccff_shift=0; start=1 -> LOAD, bit_cnt cleared to 0.
REQ-019 LOAD: busy=1, din_ready=1, ccff_shift=0; on din_valid=1, capture din into the shift register, clear the per-word counter, go to SHIFT; on din_valid=0, stay in LOAD with bit_cnt held (stall).
REQ-020 SHIFT: busy=1, din_ready=0, ccff_shift=1, ccff_head=shift-register MSB; each cycle, shift the register left by one and increment bit_cnt and the per-word counter.
REQ-021 SHIFT exit: when bit_cnt reaches CHAIN_LEN after an increment -> DONE; else when DATA_W bits of the word are sent -> LOAD.
REQ-022 If CHAIN_LEN is not a multiple of DATA_W, the unsent low-order bits of the final word SHALL be discarded.
REQ-023 DONE: done=1 for exactly one cycle, busy=1, then -> IDLE; bit_cnt SHALL hold CHAIN_LEN until the next start.
REQ-024 Latency: a word accepted at edge N SHALL drive its MSB on ccff_head with ccff_shift=1 in the cycle following edge N; one word SHALL take DATA_W+1 cycles.
REQ-025 ccff_head and ccff_shift SHALL be driven from flops or decoded state only, with no combinational path from any input.
REQ-026 ccff_head SHALL be 0 whenever ccff_shift=0.
REQ-027 start asserted while busy=1 SHALL be ignored and SHALL set err; err SHALL clear only on reset.
REQ-028 abort=1 in LOAD or SHIFT SHALL go to IDLE next cycle with no done pulse, ccff_shift=0 from that cycle, and bit_cnt holding the bits sent.
REQ-029 abort has priority over start and din_valid when both are asserted in the same cycle.
REQ-030 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-031 RSTN=0 SHALL immediately force IDLE with ccff_head=0, ccff_shift=0, din_ready=0, busy=0, done=0, err=0, bit_cnt=0 and the shift register at 0, including mid-SHIFT.
REQ-032 The first start SHALL be honoured on the first CK edge after RSTN deasserts.

Verification
REQ-033 With DATA_W=8 and CHAIN_LEN=16, feeding 0xA5 then 0x3C with no stalls -> ccff_head sequence 1010_0101_0011_1100 on 16 ccff_shift cycles, done pulse, bit_cnt=16, 18 cycles from the start edge to DONE.
REQ-034 With CHAIN_LEN=12, feeding 0xFF then 0x0F -> 12 shifts only, head bits 1111_1111_0000, bit_cnt=12, done pulse.
REQ-035 Holding din_valid=0 for 5 cycles in LOAD -> ccff_shift=0, din_ready=1 and bit_cnt constant for 5 cycles, then normal shift resumes.
REQ-036 Abort after 3 bits of 0xA5 -> IDLE, no done, bit_cnt=3, ccff_shift=0; a following start runs a full clean load.
REQ-037 start pulsed during SHIFT -> err=1 and the load is unaffected.
REQ-038 RSTN low mid-SHIFT -> all outputs 0 asynchronously, before the next CK edge.
